// File: rtl/if_fetch_stage_pkg.sv
// Shared widths, reset constants and fetch-FSM encodings for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam int INSTR_WIDTH = 32;

  localparam logic [INSTR_WIDTH-1:0] RESET_PC  = 32'hBFC0_0000;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [1:0] IF_FETCH = 2'd0;
  localparam logic [1:0] IF_HOLD  = 2'd1;
  localparam logic [1:0] IF_DROP  = 2'd2;

  // Redirect targets are words; the two byte-offset bits are discarded.
  function automatic logic [INSTR_WIDTH-1:0] word_align(input logic [INSTR_WIDTH-1:0] addr);
    return addr & {{(INSTR_WIDTH-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry {instr, PC} buffer that parks a fetched word while IF/ID is stalled.
// Load takes effect next cycle; clear has priority over load.
module if_hold_buf
  import if_fetch_stage_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load,
  input  logic                   i_clear,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [INSTR_WIDTH-1:0] i_pc,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [INSTR_WIDTH-1:0] o_pc,
  output logic                   o_valid
);

  logic [INSTR_WIDTH-1:0] r_instr;
  logic [INSTR_WIDTH-1:0] r_pc;
  logic                   r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, runs the imem req/ack handshake and feeds IF/ID.
// Zero-wait acks are presented the same cycle; a stall parks the word in a one-entry hold buffer.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [INSTR_WIDTH-1:0] redirect_pc_i,
  output logic                   imem_req_o,
  output logic [INSTR_WIDTH-1:0] imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [INSTR_WIDTH-1:0] W_IF_instr_o,
  output logic [INSTR_WIDTH-1:0] W_IF_PC_o,
  output logic                   if_valid_o,
  output logic                   if_busy_o
);

  logic [1:0]             r_state;
  logic [INSTR_WIDTH-1:0] r_pc;
  logic [INSTR_WIDTH-1:0] r_pend_pc;

  logic                   w_fetching;
  logic                   w_ack;
  logic                   w_present;
  logic                   w_hold_load;
  logic                   w_hold_clear;
  logic                   w_hold_vld;
  logic [INSTR_WIDTH-1:0] w_hold_instr;
  logic [INSTR_WIDTH-1:0] w_hold_pc;
  logic [INSTR_WIDTH-1:0] w_redir_pc;
  logic [INSTR_WIDTH-1:0] w_pc_inc;

  // An ack only counts while a request is up; in HOLD the request is down.
  assign w_fetching   = (r_state != IF_HOLD);
  assign w_ack        = imem_ack_i && w_fetching;
  assign w_present    = (r_state == IF_FETCH) && w_ack && !redirect_i;
  assign w_redir_pc   = word_align(redirect_pc_i);
  assign w_pc_inc     = r_pc + INSTR_WIDTH'(4);
  assign w_hold_load  = w_present && stall_i;
  assign w_hold_clear = (r_state == IF_HOLD) && (redirect_i || !stall_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IF_FETCH;
      r_pc      <= RESET_PC;
      r_pend_pc <= '0;
    end else begin
      case (r_state)
        IF_FETCH: begin
          if (w_ack) begin
            if (redirect_i) begin
              r_pc <= w_redir_pc;
            end else begin
              r_pc <= w_pc_inc;
              if (stall_i) r_state <= IF_HOLD;
            end
          end else if (redirect_i) begin
            r_pend_pc <= w_redir_pc;
            r_state   <= IF_DROP;
          end
        end
        IF_HOLD: begin
          if (redirect_i) begin
            r_pc    <= w_redir_pc;
            r_state <= IF_FETCH;
          end else if (!stall_i) begin
            r_state <= IF_FETCH;
          end
        end
        IF_DROP: begin
          // The outstanding word belongs to the old path; the latest redirect wins.
          if (w_ack) begin
            r_pc    <= redirect_i ? w_redir_pc : r_pend_pc;
            r_state <= IF_FETCH;
          end else if (redirect_i) begin
            r_pend_pc <= w_redir_pc;
          end
        end
        default: r_state <= IF_FETCH;
      endcase
    end
  end

  if_hold_buf u_hold_buf (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_load  (w_hold_load),
    .i_clear (w_hold_clear),
    .i_instr (imem_rdata_i),
    .i_pc    (r_pc),
    .o_instr (w_hold_instr),
    .o_pc    (w_hold_pc),
    .o_valid (w_hold_vld)
  );

  // Outputs are gated by reset so a stray ack during reset cannot look like a fetch.
  assign imem_req_o  = rst && w_fetching;
  assign imem_addr_o = r_pc;
  assign if_busy_o   = rst && w_fetching && !imem_ack_i;

  always_comb begin
    W_IF_instr_o = NOP_INSTR;
    W_IF_PC_o    = r_pc;
    if_valid_o   = 1'b0;
    if (r_state == IF_HOLD) begin
      W_IF_instr_o = w_hold_instr;
      W_IF_PC_o    = w_hold_pc;
      if_valid_o   = rst && w_hold_vld;
    end else if (rst && w_present) begin
      W_IF_instr_o = imem_rdata_i;
      if_valid_o   = 1'b1;
    end
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage: owns the architectural PC, issues word fetches to instruction memory over a req/ack handshake, and presents {instruction, PC} to the IF/ID pipeline register.
- Absorbs variable memory latency, downstream stalls (one-entry hold buffer) and branch/jump redirects, including redirects that arrive while a fetch is outstanding (stale response dropped).
- Sits between the hazard/branch logic (stall, redirect) and IF/ID.

Parameters:
- INSTR_WIDTH, 32, instruction and PC width (shared `INSTR_WIDTH`).
- RESET_PC, 32'hBFC0_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, instruction driven when no valid fetch is presented (bubble).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall_i  in  1  downstream stall (the same signal driving IF/ID's en); 1 = IF/ID holds.
- redirect_i  in  1  branch/jump taken; has priority over sequential fetch.
- redirect_pc_i  in  INSTR_WIDTH  redirect target (word aligned).
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  INSTR_WIDTH  fetch address; stable while req=1 and no ack.
- imem_ack_i  in  1  response strobe; imem_rdata_i valid this cycle.
- imem_rdata_i  in  INSTR_WIDTH  fetched instruction.
- W_IF_instr_o  out  INSTR_WIDTH  instruction to IF/ID.
- W_IF_PC_o  out  INSTR_WIDTH  PC of W_IF_instr_o.
- if_valid_o  out  1  W_IF_* carry a real instruction.
- if_busy_o  out  1  fetch outstanding without ack (to hazard unit).

Behaviour:
- Reset (rst=0, async):
  - state=FETCH, pc=RESET_PC, hold_valid=0, pend_pc=0.
  - Outputs: imem_req_o=0, W_IF_instr_o=NOP_INSTR, W_IF_PC_o=RESET_PC, if_valid_o=0, if_busy_o=0.
  - The first request is issued in the first cycle after rst deasserts.
- Handshake:
  - imem_req_o and imem_addr_o are held until the cycle imem_ack_i=1.
  - Ack may arrive in the same cycle req first rises (zero-wait).
  - ack while req=0 is a protocol error and is ignored.
- States:
  - FETCH: req=1, addr=pc.
    - ack & redirect_i: discard data; pc<=redirect_pc_i; stay FETCH.
    - ack & !stall_i: present data this cycle (valid=1); pc<=pc+4; stay FETCH. This gives a back-to-back fetch with no bubble.
    - ack & stall_i: present data; capture {rdata, pc} into hold; pc<=pc+4; go to HOLD.
    - no ack & redirect_i: pend_pc<=redirect_pc_i; go to DROP.
    - no ack, otherwise: hold.
  - HOLD: req=0; outputs driven from hold regs, valid=1.
    - redirect_i: clear hold; pc<=redirect_pc_i; go to FETCH.
    - !stall_i: IF/ID captures this cycle; clear hold; go to FETCH. The next request is issued the following cycle (one-cycle bubble, accepted).
    - stall_i: remain in HOLD.
  - DROP: req=1, addr=old pc (held per the handshake).
    - ack: data discarded; pc<=pend_pc; go to FETCH.
    - further redirect_i while in DROP: pend_pc<=new target; the latest redirect wins.
    - ack & redirect_i in the same cycle: pc<=redirect_pc_i.
- Output mux:
  - HOLD: hold regs, valid=1.
  - FETCH & ack & !redirect_i: {rdata, pc}, valid=1.
  - Otherwise: {NOP_INSTR, pc}, valid=0.
- if_busy_o = (state==FETCH or DROP) & !imem_ack_i.
- Arithmetic: pc+4 is modulo 2^INSTR_WIDTH (0xFFFF_FFFC -> 0x0000_0000). redirect_pc_i[1:0] is ignored and forced to 00.
- Priority in all states: rst > redirect_i > stall_i > sequential.
- Reset mid-request: state is discarded immediately; a late ack after reset release, arriving with req=0, is ignored.

Decomposition:
- Shared defines: INSTR_WIDTH, RESET_PC, NOP_INSTR, 2-bit state encodings IF_FETCH/IF_HOLD/IF_DROP.
- One natural sub-module: if_hold_buf, a one-entry {instr, PC} buffer with load/clear/valid and async active-low reset.
- The PC register and FSM stay in the top level.

Test Plan:
- Reset then zero-wait memory (ack same cycle as req), no stall -> valid instrs at PCs BFC00000, BFC00004, BFC00008 on consecutive cycles; req continuously 1.
- Memory with 3-cycle latency -> req/addr stable for 3 cycles; if_busy_o=1 for the first 2 of them; valid=1 only on the ack cycle; next addr = prev+4.
- stall_i=1 on the ack cycle for PC BFC00010, held 4 cycles -> HOLD state; outputs stay {instr, BFC00010} with valid=1; req=0. On release, the next req addr is BFC00014.
- redirect_i to 80001000 while an ack is pending for BFC00020 -> addr stays BFC00020 until ack; that data is dropped (valid=0); next req addr is 80001000.
- Two redirects during DROP (80001000, then 80002000) plus ack & redirect 80003000 in one FETCH cycle -> fetch resumes at 80002000; then the next addr is 80003000 and the acked word is discarded.
- rst asserted mid-wait, ack arriving after release with req=0 -> ignored; first valid PC is BFC00000. Also cover pc wrap FFFFFFFC -> 00000000.
